// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and stage-count helper for the pipelined adders of the Vedic multiplier tree
package adder_pkg;

    localparam int ADD_WIDTH_DEFAULT = 64;
    localparam int ADD_SEG_W_DEFAULT = 16;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg: combinational W-bit slice adder with carry in/out
module adder_seg #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-segmented pipelined adder, one SEG_W slice per stage, valid/ready flow control
// Defining PIPELINED_ADDER_SUB_EN adds a sub port selecting a - b.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT,
    parameter int SEG_W = ADD_SEG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    if (WIDTH % SEG_W != 0 || NSEG < 1) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG_W");
    end

    logic                        en;
    logic [WIDTH-1:0]            b_eff;
    logic                        cin_eff;
    logic [NSEG-1:0]             v, c, vi, ci, co;
    logic [NSEG-1:0][WIDTH-1:0]  x, y, xi, yi, xn;
    logic [NSEG-1:0][SEG_W-1:0]  s;
    logic                        unused_y;

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction is folded into the operands at entry, so it travels with its operation.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = v[NSEG-1];
    assign sum       = x[NSEG-1];
    assign cout      = c[NSEG-1];
    assign unused_y  = ^y[NSEG-1];

    // x carries finished sum slices below the stage and untouched a slices above; y carries b
    always_comb begin
        xi[0] = a;
        yi[0] = b_eff;
        ci[0] = cin_eff;
        vi[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            xi[k] = x[k-1];
            yi[k] = y[k-1];
            ci[k] = c[k-1];
            vi[k] = v[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            xn[k] = xi[k];
            xn[k][k*SEG_W +: SEG_W] = s[k];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        adder_seg #(.W(SEG_W)) u_seg (
            .a    (xi[k][k*SEG_W +: SEG_W]),
            .b    (yi[k][k*SEG_W +: SEG_W]),
            .cin  (ci[k]),
            .sum  (s[k]),
            .cout (co[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            c <= '0;
            x <= '0;
            y <= '0;
        end else if (en) begin
            v <= vi;
            c <= co;
            x <= xn;
            y <= yi;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of pipelined_adder against a queue-based reference model
module tb_pipelined_adder;

    localparam int NSEG = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 0;
    logic        sb = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [63:0] sum;
    logic        cout;

    int checks = 0;
    int errors = 0;
    logic [64:0] q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(64), .SEG_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sb),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    function automatic logic [64:0] model(logic [63:0] x, logic [63:0] y, logic c, logic s);
        return s ? (65'h1_0000_0000_0000_0000 + {1'b0, x} - {1'b0, y})
                 : ({1'b0, x} + {1'b0, y} + {64'd0, c});
    endfunction

    task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshake seen before the edge, then step to #1 after it.
    task automatic cycle();
        #1;
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_result: observed %h expected none", {cout, sum});
                end
                if (q.size() != 0) chk("result", {cout, sum}, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sb));
        end
        @(posedge clk);
        #1;
        if (rst) q.delete();
    endtask

    task automatic run_one(string tag, logic [63:0] ta, logic [63:0] tb2, logic tc, logic ts,
                           logic [64:0] exp);
        int lat;
        a = ta; b = tb2; cin = tc; sb = ts; in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        chk({tag, "_latency"}, 65'(lat), 65'(NSEG));
        chk(tag, {cout, sum}, exp);
        cycle();
        chk({tag, "_one_cycle"}, {64'd0, out_valid}, 65'd0);
    endtask

    initial begin
        int n;
        logic [63:0] s0;
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        chk("reset_out_valid", {64'd0, out_valid}, 65'd0);
        chk("reset_sum", {cout, sum}, 65'd0);
        chk("reset_in_ready", {64'd0, in_ready}, 65'd1);

        run_one("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b1, 64'd0});
        run_one("seg_boundary", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 65'h0_0000_0000_0001_0000);

        // Streaming: result i appears after edge i+NSEG-1 and every cycle after that.
        for (int j = 1; j <= 13; j++) begin
            in_valid = (j <= 8);
            a = 64'(j); b = 64'(3 * j); cin = 0; sb = 0;
            if (j <= 8) chk("stream_in_ready", {64'd0, in_ready}, 65'd1);
            cycle();
            chk("stream_valid", {64'd0, out_valid}, {64'd0, (j >= NSEG && j < NSEG + 8)});
            if (j >= NSEG && j < NSEG + 8) chk("stream_sum", {cout, sum}, 65'(4 * (j - NSEG + 1)));
        end

        // Backpressure: fill with out_ready low, hold, then drain.
        out_ready = 0;
        n = 0;
        while (in_ready && n < 10) begin
            in_valid = 1; a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
            cin = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        chk("fill_depth", 65'(n), 65'(NSEG));
        s0 = sum;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("stall_in_ready", {64'd0, in_ready}, 65'd0);
            chk("stall_valid", {64'd0, out_valid}, 65'd1);
            chk("stall_sum", {1'b0, sum}, {1'b0, s0});
        end
        in_valid = 0;
        out_ready = 1;
        for (int j = 0; j < 8; j++) cycle();
        chk("drain_empty", 65'(q.size()), 65'd0);

        // Random traffic with random backpressure.
        for (int j = 0; j < 400; j++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom(), $urandom()};
            b = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom(), $urandom()};
            cin = 1'($urandom_range(0, 1));
`ifdef PIPELINED_ADDER_SUB_EN
            sb = 1'($urandom_range(0, 1));
`endif
            cycle();
        end
        in_valid = 0;
        out_ready = 1;
        sb = 0;
        for (int j = 0; j < 10; j++) cycle();
        chk("random_drain_empty", 65'(q.size()), 65'd0);

        // Reset with three operations in flight; none may emerge.
        for (int j = 0; j < 3; j++) begin
            in_valid = 1; a = 64'(100 + j); b = 64'(j); cin = 0;
            cycle();
        end
        in_valid = 0;
        rst = 1;
        cycle();
        rst = 0;
        chk("midreset_valid", {64'd0, out_valid}, 65'd0);
        chk("midreset_sum", {cout, sum}, 65'd0);
        chk("midreset_in_ready", {64'd0, in_ready}, 65'd1);
        n = 0;
        for (int j = 0; j < 8; j++) begin
            cycle();
            if (out_valid) n++;
        end
        chk("midreset_no_results", 65'(n), 65'd0);

`ifdef PIPELINED_ADDER_SUB_EN
        run_one("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        run_one("sub_no_borrow", 64'd7, 64'd5, 1'b0, 1'b1, {1'b1, 64'd2});
        run_one("add_after_sub", 64'd7, 64'd5, 1'b1, 1'b0, 65'd13);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
